// File: rtl/dht_uart_reporter.sv
// Captures a DHT11 reading, converts each byte to 3 ASCII decimal digits by double-dabble,
// and streams the fixed 19-character text frame out over an 8N1 UART.
module dht_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] RH_integral,
    input  logic [7:0] RH_decimal,
    input  logic [7:0] T_integral,
    input  logic [7:0] T_decimal,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] overrun_cnt
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] BIT_PENULT = TW'(CLKS_PER_BIT - 2);
    localparam logic [4:0]    LAST_IDX   = 5'd18;

    typedef enum logic [2:0] {
        StIdle, StConv, StLoad, StStart, StData, StStop, StDone
    } state_e;

    state_e        r_state;
    logic [19:0]   r_dd [4];     // {hundreds, tens, ones, binary} per byte
    logic [2:0]    r_conv_cnt;
    logic [4:0]    r_idx;
    logic [2:0]    r_bit_cnt;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_frame_done;
    logic [7:0]    r_overrun_cnt;

    logic          w_accept;
    logic          w_drop;
    logic [7:0]    w_char;

    assign w_accept = data_valid & ~r_busy;
    assign w_drop   = data_valid & r_busy;

    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int n = 0; n < 3; n++) begin
            if (t[8+4*n +: 4] > 4'd4) t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    always_comb begin
        w_char = 8'h0A;
        case (r_idx)
            5'd0:    w_char = 8'h48;
            5'd1:    w_char = {4'h3, r_dd[0][19:16]};
            5'd2:    w_char = {4'h3, r_dd[0][15:12]};
            5'd3:    w_char = {4'h3, r_dd[0][11:8]};
            5'd4:    w_char = 8'h2E;
            5'd5:    w_char = {4'h3, r_dd[1][19:16]};
            5'd6:    w_char = {4'h3, r_dd[1][15:12]};
            5'd7:    w_char = {4'h3, r_dd[1][11:8]};
            5'd8:    w_char = 8'h20;
            5'd9:    w_char = 8'h54;
            5'd10:   w_char = {4'h3, r_dd[2][19:16]};
            5'd11:   w_char = {4'h3, r_dd[2][15:12]};
            5'd12:   w_char = {4'h3, r_dd[2][11:8]};
            5'd13:   w_char = 8'h2E;
            5'd14:   w_char = {4'h3, r_dd[3][19:16]};
            5'd15:   w_char = {4'h3, r_dd[3][15:12]};
            5'd16:   w_char = {4'h3, r_dd[3][11:8]};
            5'd17:   w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state       <= StIdle;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun_cnt <= 8'd0;
            r_conv_cnt    <= 3'd0;
            r_idx         <= 5'd0;
            r_bit_cnt     <= 3'd0;
            r_timer       <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_drop && r_overrun_cnt != 8'hFF) r_overrun_cnt <= r_overrun_cnt + 8'd1;

            case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        r_dd[0]    <= {12'd0, RH_integral};
                        r_dd[1]    <= {12'd0, RH_decimal};
                        r_dd[2]    <= {12'd0, T_integral};
                        r_dd[3]    <= {12'd0, T_decimal};
                        r_conv_cnt <= 3'd0;
                        r_idx      <= 5'd0;
                        r_busy     <= 1'b1;
                        r_state    <= StConv;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StConv: begin
                    for (int k = 0; k < 4; k++) r_dd[k] <= dd_step(r_dd[k]);
                    r_conv_cnt <= r_conv_cnt + 3'd1;
                    if (r_conv_cnt == 3'd7) r_state <= StLoad;
                end
                // Occupies the final cycle of the previous stop bit (or idle), so no gap.
                StLoad: begin
                    r_shift <= w_char;
                    r_tx    <= 1'b0;
                    r_timer <= '0;
                    r_state <= StStart;
                end
                StStart: begin
                    r_timer <= r_timer + 1'b1;
                    if (r_timer == BIT_LAST) begin
                        r_timer   <= '0;
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= 3'd0;
                        r_state   <= StData;
                    end
                end
                StData: begin
                    r_timer <= r_timer + 1'b1;
                    if (r_timer == BIT_LAST) begin
                        r_timer <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                StStop: begin
                    r_timer <= r_timer + 1'b1;
                    if (r_idx != LAST_IDX && r_timer == BIT_PENULT) begin
                        r_idx   <= r_idx + 5'd1;
                        r_state <= StLoad;
                    end else if (r_idx == LAST_IDX && r_timer == BIT_LAST) begin
                        r_timer      <= '0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_dht_uart_reporter.sv
// Directed bench for dht_uart_reporter at CLKS_PER_BIT=4: decodes the UART line
// sample by sample and checks frame text, bit timing, handshakes and overrun counting.
module tb_dht_uart_reporter;

    localparam int unsigned CPB = 4;
    localparam int unsigned FRAME_CYC = 190 * CPB;

    logic       clk_50M = 1'b0;
    logic       reset = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] RH_integral = 8'd0;
    logic [7:0] RH_decimal = 8'd0;
    logic [7:0] T_integral = 8'd0;
    logic [7:0] T_decimal = 8'd0;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] overrun_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    dht_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .data_valid  (data_valid),
        .RH_integral (RH_integral),
        .RH_decimal  (RH_decimal),
        .T_integral  (T_integral),
        .T_decimal   (T_decimal),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        n_chk++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    task automatic set_bytes(input logic [31:0] b);
        RH_integral = b[31:24];
        RH_decimal  = b[23:16];
        T_integral  = b[15:8];
        T_decimal   = b[7:0];
    endtask

    // Called at a negedge; one-cycle data_valid pulse.
    task automatic send(input logic [31:0] b);
        set_bytes(b);
        data_valid = 1'b1;
        @(negedge clk_50M);
        data_valid = 1'b0;
    endtask

    // Waits for the start bit, captures one frame, optionally injects drop pulses mid-frame
    // and optionally accepts a new reading in the frame_done cycle.
    task automatic run_frame(input string tag, input string exp, input int n_drops,
                             input logic boundary, input logic [31:0] nxt);
        logic       samp [FRAME_CYC];
        int         lat;
        int         fd_cnt;
        int         busy_low;
        logic       bits_ok;
        logic       v;
        logic [7:0] ch;
        string      got;
        lat = 0;
        fd_cnt = 0;
        busy_low = 0;
        bits_ok = 1'b1;
        got = "";
        while (tx !== 1'b0 && lat < 64) begin
            @(negedge clk_50M);
            lat++;
        end
        check({tag, " start_within_64"}, {31'd0, tx}, 32'd0);
        for (int i = 0; i < int'(FRAME_CYC); i++) begin
            if (i > 0) @(negedge clk_50M);
            samp[i] = tx;
            if (frame_done === 1'b1) fd_cnt++;
            if (busy !== 1'b1) busy_low++;
            if (i >= 100 && i < 100 + 2 * n_drops && (i % 2) == 0) begin
                set_bytes(32'h63584D42);
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
        end
        for (int c = 0; c < 19; c++) begin
            ch = 8'h00;
            for (int b = 0; b < 10; b++) begin
                v = samp[c*40 + b*4];
                for (int j = 1; j < 4; j++) if (samp[c*40 + b*4 + j] !== v) bits_ok = 1'b0;
                if (b == 0 && v !== 1'b0) bits_ok = 1'b0;
                if (b == 9 && v !== 1'b1) bits_ok = 1'b0;
                if (b >= 1 && b <= 8) ch[b-1] = v;
            end
            got = $sformatf("%s%c", got, ch);
        end
        check_str({tag, " text"}, got, exp);
        check({tag, " bit_framing"}, {31'd0, bits_ok}, 32'd1);
        check({tag, " no_early_done"}, fd_cnt, 0);
        check({tag, " busy_in_frame"}, busy_low, 0);
        @(negedge clk_50M);
        check({tag, " frame_done"}, {31'd0, frame_done}, 32'd1);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        if (boundary) begin
            set_bytes(nxt);
            data_valid = 1'b1;
        end
        @(negedge clk_50M);
        data_valid = 1'b0;
        check({tag, " done_one_cycle"}, {31'd0, frame_done}, 32'd0);
        check({tag, " busy_after"}, {31'd0, busy}, {31'd0, boundary});
    endtask

    initial begin
        int tx_low;
        int fd_seen;
        int lat;

        // Reset with data_valid toggling
        set_bytes(32'h3C00_1903);
        @(negedge clk_50M);
        for (int i = 0; i < 3; i++) begin
            data_valid = ~data_valid;
            @(negedge clk_50M);
            check("rst tx", {31'd0, tx}, 32'd1);
            check("rst busy", {31'd0, busy}, 32'd0);
            check("rst frame_done", {31'd0, frame_done}, 32'd0);
            check("rst overrun", {24'd0, overrun_cnt}, 32'd0);
        end
        data_valid = 1'b0;
        reset = 1'b0;
        tx_low = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_50M);
            if (tx !== 1'b1 || busy !== 1'b0) tx_low++;
        end
        check("no frame after reset", tx_low, 0);

        // Nominal and extreme values
        send(32'h3C00_1903);
        check("nominal busy after accept", {31'd0, busy}, 32'd1);
        run_frame("nominal", "H060.000 T025.003\r\n", 0, 1'b0, 32'd0);
        send(32'hFF00_00FF);
        run_frame("extremes", "H255.000 T000.255\r\n", 0, 1'b0, 32'd0);

        // Drops mid-frame keep the original bytes; then saturation and boundary accept
        send(32'h0B16_212C);
        run_frame("overrun3", "H011.022 T033.044\r\n", 3, 1'b0, 32'd0);
        check("overrun count 3", {24'd0, overrun_cnt}, 32'd3);
        send(32'h0506_0708);
        run_frame("overrun300", "H005.006 T007.008\r\n", 300, 1'b1, 32'h0102_0304);
        check("overrun saturated", {24'd0, overrun_cnt}, 32'd255);
        run_frame("boundary", "H001.002 T003.004\r\n", 0, 1'b0, 32'd0);
        check("boundary not dropped", {24'd0, overrun_cnt}, 32'd255);

        // Reset during the data bits of character 7
        send(32'hC864_3209);
        lat = 0;
        while (tx !== 1'b0 && lat < 64) begin
            @(negedge clk_50M);
            lat++;
        end
        check("midrst start", {31'd0, tx}, 32'd0);
        repeat (295) @(negedge clk_50M);
        reset = 1'b1;
        @(negedge clk_50M);
        check("midrst tx", {31'd0, tx}, 32'd1);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst overrun", {24'd0, overrun_cnt}, 32'd0);
        reset = 1'b0;
        tx_low = 0;
        fd_seen = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk_50M);
            if (tx !== 1'b1) tx_low++;
            if (frame_done === 1'b1) fd_seen++;
        end
        check("midrst no frame_done", fd_seen, 0);
        check("midrst line idle", tx_low, 0);
        send(32'h0708_090A);
        run_frame("after reset", "H007.008 T009.010\r\n", 0, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dht_uart_reporter.md
Name: dht_uart_reporter

Overview:
Downstream consumer of the DHT11 reader. It captures each validated reading (the data_valid pulse plus the four data bytes) and converts every byte to three ASCII decimal digits. It then transmits a fixed 19-character text frame over an 8N1 UART TX line for logging or a host link. Readings that arrive while a frame is still in flight are dropped and counted.

Parameters:
CLKS_PER_BIT, 434, clk_50M cycles per UART bit (434 ≈ 115200 baud at 50 MHz); legal range ≥ 2.

Ports:
clk_50M  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
data_valid  input  1  one-cycle pulse: the data bytes are valid this cycle
RH_integral  input  8  humidity integral byte
RH_decimal  input  8  humidity decimal byte
T_integral  input  8  temperature integral byte
T_decimal  input  8  temperature decimal byte
tx  output  1  UART serial out, idle high
busy  output  1  high while a capture is being converted or transmitted
frame_done  output  1  one-cycle pulse after the last stop bit of a frame
overrun_cnt  output  8  count of dropped readings; saturates at 255

Behaviour:
- Reset: applies when reset=1 at a clk_50M edge. tx=1, busy=0, frame_done=0, overrun_cnt=0, FSM=IDLE. The capture registers and digit buffer are don't-care.
- Reset mid-frame aborts the frame. tx is 1 on the cycle after the reset edge, no frame_done is generated, and overrun_cnt clears.
- Accept rule: data_valid=1 while registered busy=0 latches all four bytes into internal registers. busy=1 from the next cycle.
- Drop rule: data_valid=1 while busy=1 leaves the latched bytes unchanged and increments overrun_cnt by 1. overrun_cnt holds at 255 once it reaches 255.
- Frame content, in order, each byte a zero-padded 3-digit decimal (000–255):
  - 'H' (0x48), d(RH_integral), '.' (0x2E), d(RH_decimal), ' ' (0x20)
  - 'T' (0x54), d(T_integral), '.', d(T_decimal), CR (0x0D), LF (0x0A)
  - Total 19 characters.
- Conversion: sequential binary-to-BCD, either double-dabble or repeated subtraction.
  - Implementations must not use a combinational divider.
  - All 12 digits must be ready within 48 cycles of capture.
  - The start bit of character 0 must begin no later than 64 cycles after the accept edge.
- UART: 8N1, LSB first.
  - Each start, data and stop bit holds for exactly CLKS_PER_BIT cycles.
  - Consecutive characters are back-to-back: the next start bit follows the previous stop bit immediately, with no idle gap.
  - Frame length is exactly 190×CLKS_PER_BIT cycles from the first start-bit edge to the end of the last stop bit.
- FSM states:
  - IDLE: waits for an accept; moves to CONV.
  - CONV: performs the BCD conversion; moves to LOAD when all digits are done.
  - LOAD: selects character[idx], idx 0..18; moves to START.
  - START: drives tx=0 for one bit time; moves to DATA.
  - DATA: shifts out 8 bits, bit counter 0..7; moves to STOP.
  - STOP: drives tx=1 for one bit time. If idx<18, increments idx and moves to LOAD; otherwise moves to DONE.
  - DONE: asserts frame_done for exactly one cycle and returns to IDLE.
  - LOAD takes no bit time: the character is loaded in the same cycle the START bit timer begins, so there is no gap.
- busy is high from the cycle after accept through the last STOP cycle, and is 0 in the DONE cycle. A data_valid that coincides with the frame_done cycle is therefore accepted, not dropped.
- The bit timer counts 0..CLKS_PER_BIT-1 and wraps. The character index does not wrap past 18.
- Input bytes are not checked: checksum validation is upstream's job. All 256 values per byte are legal.

Test Plan:
- Reset values: hold reset=1 for 3 cycles with data_valid toggling -> tx=1, busy=0, frame_done=0, overrun_cnt=0 throughout; no frame is sent.
- Nominal frame (CLKS_PER_BIT=4): RH=60/0, T=25/3, data_valid pulse -> UART decode yields the ASCII string "H060.000 T025.003" + 0x0D 0x0A, 190×4=760 cycles from the first start edge, then one frame_done pulse and busy=0.
- Extremes: RH=255/0, T=0/255 -> "H255.000 T000.255\r\n". All bit periods measure exactly 4 cycles, and consecutive characters are sent with no idle gap.
- Overrun: accept a reading, then pulse data_valid 3 times mid-frame with different bytes -> the frame carries the original bytes and overrun_cnt=3. A further 300 drops -> overrun_cnt=255 (saturated).
- Boundary accept: pulse data_valid in the same cycle as frame_done -> accepted (overrun_cnt unchanged), busy=1 on the next cycle, and a second frame starts within 64 cycles.
- Reset mid-frame: assert reset during the DATA bits of character 7 -> tx=1 on the next cycle, no frame_done, overrun_cnt=0. A subsequent data_valid produces a complete, correct frame.
